// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage.
// Owns the 8-bit program counter, reads the combinational program ROM once
// per cycle and buffers each {pc, byte} pair in a small FIFO that decode
// drains through a valid/ready handshake. A redirect flushes the FIFO and
// reloads the PC; halt stops fetching while the queue keeps draining.
module fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    input  logic       halt
);

    // Pointer width is log2(DEPTH) so pointers wrap modulo DEPTH for free;
    // the count needs one extra value to represent a full queue.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    pc_q;
    logic [7:0]    pc_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [15:0]   mem_q [DEPTH];

    logic          full;
    logic          pop;
    logic          fetch;
    logic [15:0]   head;

    // Handshake and fetch decision; a pop frees a slot in the same cycle,
    // which is what keeps a full queue streaming at one byte per cycle.
    always_comb begin
        full        = (count_q == FULL_COUNT);
        instr_valid = (count_q != '0);
        pop         = instr_valid & instr_ready;
        fetch       = ~halt & ~redirect & (~full | pop);
    end

    // Program counter: redirect wins over halt; otherwise advance on fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (fetch) begin
            pc_d = pc_q + 8'd1;
        end
    end

    // Queue pointers: a redirect flushes everything, including a same-cycle pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (fetch) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Occupancy: pop and fetch together leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else if (fetch && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !fetch) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset discards all queued entries immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: each fetch captures the PC together with the ROM byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fetch) begin
            mem_q[wr_ptr_q] <= {pc_q, rom_data};
        end
    end

    // Head presentation; an empty queue drives zeros rather than stale data.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        rom_addr = pc_q;
        instr    = instr_valid ? head[7:0]  : 8'h00;
        instr_pc = instr_valid ? head[15:8] : 8'h00;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of the fetch queue against a ROM whose
// contents are ROM[n] = n + 5 (modulo 256).
module tb_fetch_queue;

    typedef struct {
        logic       ready;
        logic       halt;
        logic       redir;
        logic [7:0] redirPc;
        logic       expValid;
        logic [7:0] expInstr;
        logic [7:0] expPc;
        logic [7:0] expRom;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;

    int checks;
    int errors;
    vec_t vecs[$];

    fetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    // Combinational program ROM.
    assign rom_data = rom_addr + 8'd5;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic r, logic h, logic d, logic [7:0] rpc,
                                logic v, logic [7:0] i, logic [7:0] p, logic [7:0] a);
        vec_t t;
        t.ready = r; t.halt = h; t.redir = d; t.redirPc = rpc;
        t.expValid = v; t.expInstr = i; t.expPc = p; t.expRom = a;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [7:0] i,
                               input logic [7:0] p, input logic [7:0] a);
        cmp({tag, " instr_valid"}, {7'd0, instr_valid}, {7'd0, v});
        cmp({tag, " instr"}, instr, i);
        cmp({tag, " instr_pc"}, instr_pc, p);
        cmp({tag, " rom_addr"}, rom_addr, a);
    endtask

    // Drive one cycle of inputs, let the edge happen, sample #1 after it.
    task automatic applyStimulus(input logic r, input logic h, input logic d, input logic [7:0] rpc);
        instr_ready = r;
        halt        = h;
        redirect    = d;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        instr_ready = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Streaming from reset with the decoder always ready.
        doReset();
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("stream%0d", n), 1'b1, 8'(n + 5), 8'(n), 8'(n + 1));
        end

        // Table: saturation, drain, redirect, PC wrap, halt behaviour.
        doReset();
        vecs.push_back(mk(0,0,0,8'h00, 1,8'h05,8'h00,8'h01));
        vecs.push_back(mk(0,0,0,8'h00, 1,8'h05,8'h00,8'h02));
        vecs.push_back(mk(0,0,0,8'h00, 1,8'h05,8'h00,8'h03));
        vecs.push_back(mk(0,0,0,8'h00, 1,8'h05,8'h00,8'h04));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(0,0,0,8'h00, 1,8'h05,8'h00,8'h04));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h06,8'h01,8'h05));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h07,8'h02,8'h06));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h08,8'h03,8'h07));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h09,8'h04,8'h08));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h0A,8'h05,8'h09));
        vecs.push_back(mk(1,1,0,8'h00, 1,8'h0B,8'h06,8'h09));
        vecs.push_back(mk(1,0,1,8'h80, 0,8'h00,8'h00,8'h80));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h85,8'h80,8'h81));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h86,8'h81,8'h82));
        vecs.push_back(mk(1,0,1,8'hFE, 0,8'h00,8'h00,8'hFE));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h03,8'hFE,8'hFF));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h04,8'hFF,8'h00));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h05,8'h00,8'h01));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h06,8'h01,8'h02));
        vecs.push_back(mk(0,0,0,8'h00, 1,8'h06,8'h01,8'h03));
        vecs.push_back(mk(1,1,0,8'h00, 1,8'h07,8'h02,8'h03));
        vecs.push_back(mk(1,1,0,8'h00, 0,8'h00,8'h00,8'h03));
        vecs.push_back(mk(1,1,0,8'h00, 0,8'h00,8'h00,8'h03));
        vecs.push_back(mk(1,1,1,8'h40, 0,8'h00,8'h00,8'h40));
        vecs.push_back(mk(1,1,0,8'h00, 0,8'h00,8'h00,8'h40));
        vecs.push_back(mk(1,0,0,8'h00, 1,8'h45,8'h40,8'h41));
        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].ready, vecs[v].halt, vecs[v].redir, vecs[v].redirPc);
            checkOutput($sformatf("vec%0d", v), vecs[v].expValid, vecs[v].expInstr,
                        vecs[v].expPc, vecs[v].expRom);
        end

        // Asynchronous reset mid-stream, between clock edges.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("prereset", 1'b1, 8'h46, 8'h41, 8'h42);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncreset", 1'b0, 8'h00, 8'h00, 8'h00);
        #3;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
